// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states,
// instruction classes, data-processing commands and datapath mux selects.
package cpu_ctrl_pkg;

    // FSM state encodings
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;

    typedef enum logic [3:0] {
        FETCH    = ST_FETCH,
        DECODE   = ST_DECODE,
        MEMADR   = ST_MEMADR,
        MEMREAD  = ST_MEMREAD,
        MEMWB    = ST_MEMWB,
        MEMWRITE = ST_MEMWRITE,
        EXECUTER = ST_EXECUTER,
        EXECUTEI = ST_EXECUTEI,
        ALUWB    = ST_ALUWB,
        BRANCH   = ST_BRANCH
    } state_t;

    // Instruction classes carried in op
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Data-processing command field (funct[4:1])
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RM   = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_RDATA  = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decoder: turns cmd/S into the ALU op, flag-write
// requests and the CMP write suppression. Everything is 0 when not enabled.
module alu_dec
    import cpu_ctrl_pkg::*;
(
    input  logic       en,
    input  logic [3:0] cmd,
    input  logic       s,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write,
    output logic       illegal_cmd
);

    logic arith;

    // Decode the command; unknown commands fall back to ADD and flag illegal
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        illegal_cmd = 1'b0;
        arith       = 1'b0;
        if (en) begin
            case (cmd)
                CMD_ADD: begin alu_control = ALU_ADD; arith = 1'b1; end
                CMD_SUB: begin alu_control = ALU_SUB; arith = 1'b1; end
                CMD_AND: alu_control = ALU_AND;
                CMD_ORR: alu_control = ALU_ORR;
                CMD_CMP: begin
                    alu_control = ALU_SUB;
                    arith       = 1'b1;
                    no_write    = 1'b1;
                end
                default: illegal_cmd = 1'b1;
            endcase
            // C,V only make sense for the adder/subtractor results
            flag_w = {s, s & arith};
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: sequences fetch, decode,
// execute/address, memory and writeback, driving all mux selects and the
// raw write requests consumed by the conditional-execution logic.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write,
    output logic       pcs,
    output logic       reg_w,
    output logic       mem_w,
    output logic       illegal
);

    state_t state_q, state_d;
    logic   alu_en;
    logic   branch;
    logic   illegal_dec;
    logic   illegal_cmd;

    alu_dec u_alu_dec (
        .en          (alu_en),
        .cmd         (funct[4:1]),
        .s           (funct[0]),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .no_write    (no_write),
        .illegal_cmd (illegal_cmd)
    );

    // State register; reset drops straight back to FETCH at any time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state and per-state output decode
    always_comb begin
        state_d     = state_q;
        ir_write    = 1'b0;
        next_pc     = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RM;
        result_src  = RES_ALUOUT;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        branch      = 1'b0;
        alu_en      = 1'b0;
        illegal_dec = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                next_pc    = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // PC+8 is computed here so Rn=R15 reads see it
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                case (op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_d = BRANCH;
                    default: begin
                        illegal_dec = 1'b1;
                        state_d     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_RDATA;
                reg_w      = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                // Write request held for the whole memory wait
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTER: begin
                alu_src_b = SRCB_RM;
                alu_en    = 1'b1;
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_b = SRCB_IMM;
                alu_en    = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_w      = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                branch     = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign imm_src = op;
    assign reg_src = {op == OP_MEM, op == OP_BR};
    assign pcs     = ((rd == 4'd15) & reg_w) | branch;
    assign illegal = illegal_dec | illegal_cmd;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process walks each
// instruction through its phases, pushing the expected output vector for
// every cycle; a monitor compares the DUT outputs on each falling edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mem_ready;
    logic       ir_write, next_pc, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_control, flag_w;
    logic       no_write, pcs, reg_w, mem_w, illegal;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [1:0] alu_control;
        logic [1:0] flag_w;
        logic       no_write;
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       illegal;
    } out_t;

    out_t  act;
    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    insn_no = 0;

    assign act = {ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
                  imm_src, reg_src, alu_control, flag_w, no_write, pcs, reg_w,
                  mem_w, illegal};

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .rd          (rd),
        .mem_ready   (mem_ready),
        .ir_write    (ir_write),
        .next_pc     (next_pc),
        .adr_src     (adr_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .no_write    (no_write),
        .pcs         (pcs),
        .reg_w       (reg_w),
        .mem_w       (mem_w),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Outputs that depend only on the instruction class, all others zero.
    function automatic out_t base(input logic [1:0] o);
        out_t e = '0;
        e.imm_src = o;
        e.reg_src = {o == 2'b01, o == 2'b10};
        return e;
    endfunction

    // Fetch cycle: PC+4 on the result bus, IR/PC load follows mem_ready.
    function automatic out_t fetch_exp(input logic [1:0] o, input logic mr);
        out_t e = base(o);
        e.alu_src_a  = 1'b1;
        e.alu_src_b  = 2'd2;
        e.result_src = 2'd2;
        e.ir_write   = mr;
        e.next_pc    = mr;
        return e;
    endfunction

    // Data-processing command table: ALU op, flag requests, CMP, illegal.
    function automatic out_t exec_exp(input logic [1:0] o, input logic [5:0] f);
        out_t e = base(o);
        logic arith = 1'b0;
        e.alu_src_b = f[5] ? 2'd1 : 2'd0;
        case (f[4:1])
            4'b0100: begin e.alu_control = 2'b00; arith = 1'b1; end
            4'b0010: begin e.alu_control = 2'b01; arith = 1'b1; end
            4'b0000: e.alu_control = 2'b10;
            4'b1100: e.alu_control = 2'b11;
            4'b1010: begin e.alu_control = 2'b01; arith = 1'b1; e.no_write = 1'b1; end
            default: begin e.alu_control = 2'b00; e.illegal = 1'b1; end
        endcase
        e.flag_w = {f[0], f[0] & arith};
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input out_t e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Drives one whole instruction; fw fetch wait cycles, mw memory waits.
    task automatic run_insn(input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r, input int fw, input int mw);
        out_t e;
        insn_no++;
        $display("insn %0d: op=%b funct=%b rd=%0d fetch_wait=%0d mem_wait=%0d",
                 insn_no, o, f, r, fw, mw);
        for (int i = 0; i <= fw; i++) begin
            tick();
            if (i == 0) begin op = o; funct = f; rd = r; end
            mem_ready = (i == fw);
            push(fetch_exp(o, mem_ready), "fetch");
        end
        tick();
        mem_ready = 1'($urandom);
        e = base(o);
        e.alu_src_a  = 1'b1;
        e.alu_src_b  = 2'd2;
        e.result_src = 2'd2;
        e.illegal    = (o == 2'b11);
        push(e, "decode");
        case (o)
            2'b01: begin
                tick();
                mem_ready = 1'($urandom);
                e = base(o);
                e.alu_src_b = 2'd1;
                push(e, "memadr");
                for (int i = 0; i <= mw; i++) begin
                    tick();
                    if (i > 0) begin
                        checks++;
                        if (adr_src !== 1'b1 || mem_w !== !f[0]) begin
                            errors++;
                            $display("FAIL expired_wait: adr_src=%b mem_w=%b after wait %0d (t=%0t)",
                                     adr_src, mem_w, i, $time);
                        end
                    end
                    mem_ready = (i == mw);
                    e = base(o);
                    e.adr_src = 1'b1;
                    e.mem_w   = !f[0];
                    push(e, f[0] ? "memread" : "memwrite");
                end
                if (f[0]) begin
                    tick();
                    mem_ready = 1'($urandom);
                    e = base(o);
                    e.result_src = 2'd1;
                    e.reg_w      = 1'b1;
                    e.pcs        = (r == 4'd15);
                    push(e, "memwb");
                end
            end
            2'b00: begin
                tick();
                mem_ready = 1'($urandom);
                push(exec_exp(o, f), "execute");
                tick();
                mem_ready = 1'($urandom);
                e = base(o);
                e.reg_w = 1'b1;
                e.pcs   = (r == 4'd15);
                push(e, "aluwb");
            end
            2'b10: begin
                tick();
                mem_ready = 1'($urandom);
                e = base(o);
                e.alu_src_b  = 2'd1;
                e.result_src = 2'd2;
                e.pcs        = 1'b1;
                push(e, "branch");
            end
            default: ;
        endcase
    endtask

    // ---------------- monitor ----------------
    initial begin
        out_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: dut=%h expected=%h (t=%0t)", n, act, e, $time);
                end
            end
        end
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [1:0] o;
        logic [5:0] f;
        logic [3:0] r;
        logic [3:0] cmds [5];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010;

        reset = 1'b0; mem_ready = 1'b0; op = 2'b00; funct = '0; rd = '0;
        // Reset state, IR load following mem_ready, then release while waiting
        tick(); mem_ready = 1'b0; push(fetch_exp(2'b00, 1'b0), "reset");
        tick(); mem_ready = 1'b1; push(fetch_exp(2'b00, 1'b1), "reset_irw");
        tick(); mem_ready = 1'b0; reset = 1'b1; push(fetch_exp(2'b00, 1'b0), "release");

        // Directed instructions
        run_insn(2'b00, 6'b001001, 4'd3,  0, 0);   // ADD reg, S=1
        run_insn(2'b01, 6'b000001, 4'd4,  0, 2);   // LDR, 2 waits
        run_insn(2'b01, 6'b000000, 4'd5,  1, 1);   // STR, 1 wait
        run_insn(2'b00, 6'b110101, 4'd1,  0, 0);   // CMP imm, S=1
        run_insn(2'b10, 6'b000000, 4'd0,  0, 0);   // branch
        run_insn(2'b00, 6'b111000, 4'd15, 0, 0);   // ORR imm to PC
        run_insn(2'b11, 6'b000000, 4'd2,  0, 0);   // undefined op
        run_insn(2'b00, 6'b000111, 4'd6,  0, 0);   // undefined cmd, S=1
        run_insn(2'b01, 6'b000001, 4'd15, 2, 0);   // LDR to PC

        // Reset asserted while in DECODE of a load
        $display("insn reset-mid: op=01 reset during decode");
        tick(); op = 2'b01; funct = 6'b000001; rd = 4'd7; mem_ready = 1'b1;
        push(fetch_exp(2'b01, 1'b1), "pre_reset_fetch");
        tick(); mem_ready = 1'b1; #2 reset = 1'b0;
        #1;
        checks++;
        if (reg_w !== 1'b0 || mem_w !== 1'b0 || pcs !== 1'b0 || illegal !== 1'b0 ||
            alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || result_src !== 2'd2) begin
            errors++;
            $display("FAIL reset_async: reg_w=%b mem_w=%b pcs=%b illegal=%b srca=%b srcb=%0d res=%0d (t=%0t)",
                     reg_w, mem_w, pcs, illegal, alu_src_a, alu_src_b, result_src, $time);
        end
        push(fetch_exp(2'b01, 1'b1), "reset_in_decode");
        tick(); mem_ready = 1'b1; push(fetch_exp(2'b01, 1'b1), "reset_hold");
        tick(); mem_ready = 1'b0; reset = 1'b1; push(fetch_exp(2'b01, 1'b0), "reset_release");

        // Randomized instruction stream
        repeat (300) begin
            o = 2'($urandom_range(0, 3));
            f = 6'($urandom);
            if ($urandom_range(0, 4) != 0) f[4:1] = cmds[$urandom_range(0, 4)];
            r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_insn(o, f, r, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Let the monitor drain the last expected entries
        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle CPU datapath. Decodes the instruction-register fields `op`, `funct` and `rd` and sequences one instruction over 3–5 states: fetch, decode, address/execute, memory, writeback. Drives every datapath mux select and every write-enable request. Memory waits are handled with a `mem_ready` handshake. Its raw `pcs`/`reg_w`/`mem_w`/`flag_w`/`no_write` requests feed the conditional-execution logic, which gates them with `cond_ex`.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `op` in 2: instruction class. 00 = data-processing, 01 = memory, 10 = branch, 11 = undefined.
- `funct` in 6: `[5]` = I, `[4:1]` = cmd, `[0]` = S (data-processing) or L (memory).
- `rd` in 4: destination register.
- `mem_ready` in 1: memory has completed the current access.
- `ir_write` out 1: load the instruction register.
- `next_pc` out 1: unconditional PC update (fetch increment).
- `adr_src` out 1: 0 = PC, 1 = ALU result as memory address.
- `alu_src_a` out 1: 0 = Rn, 1 = PC.
- `alu_src_b` out 2: 0 = Rm, 1 = extended immediate, 2 = constant 4.
- `result_src` out 2: 0 = ALU out register, 1 = read data, 2 = ALU result direct.
- `imm_src` out 2: equals `op`.
- `reg_src` out 2: `[0]` = (`op` == 10), `[1]` = (`op` == 01).
- `alu_control` out 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `flag_w` out 2: flag-write request; `[1]` = N,Z and `[0]` = C,V.
- `no_write` out 1: suppress register write (CMP).
- `pcs` out 1: conditional PC write request.
- `reg_w` out 1: register-write request.
- `mem_w` out 1: memory-write request.
- `illegal` out 1: one-cycle pulse on an undefined `op` or `cmd`.

## Operation
- **State register.** Updated on the rising edge of `clk`. `reset` low asynchronously forces FETCH.
- **Outputs.** Moore-decoded from the state, qualified by the current `op`/`funct`/`rd` and `mem_ready`.
- **Defaults.** Every output not listed for a state is 0.

States:
- **FETCH**
  - Outputs: `adr_src`=0, `alu_src_a`=1, `alu_src_b`=2, `result_src`=2, ALU ADD.
  - `ir_write` = `next_pc` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- **DECODE**
  - Outputs: `alu_src_a`=1, `alu_src_b`=2, `result_src`=2 (PC+8 read).
  - `op`=01 → MEMADR.
  - `op`=00 with I=0 → EXECUTER.
  - `op`=00 with I=1 → EXECUTEI.
  - `op`=10 → BRANCH.
  - `op`=11 → FETCH with `illegal`=1.
- **MEMADR**
  - Outputs: `alu_src_a`=0, `alu_src_b`=1, ALU ADD.
  - L=1 → MEMREAD; L=0 → MEMWRITE.
- **MEMREAD**
  - Outputs: `adr_src`=1.
  - Waits for `mem_ready`, then → MEMWB.
- **MEMWB**
  - Outputs: `result_src`=1, `reg_w`=1.
  - → FETCH.
- **MEMWRITE**
  - Outputs: `adr_src`=1, `mem_w`=1. `mem_w` stays high for the whole wait.
  - → FETCH when `mem_ready`=1.
- **EXECUTER**
  - Outputs: `alu_src_a`=0, `alu_src_b`=0, ALU decode active.
  - → ALUWB.
- **EXECUTEI**
  - Outputs: `alu_src_a`=0, `alu_src_b`=1, ALU decode active.
  - → ALUWB.
- **ALUWB**
  - Outputs: `result_src`=0, `reg_w`=1.
  - → FETCH.
- **BRANCH**
  - Outputs: `alu_src_a`=0, `alu_src_b`=1, `result_src`=2, ALU ADD, branch internally asserted.
  - → FETCH.

Derived outputs:
- **`pcs`** = (`rd`==15 & `reg_w`) | branch.
- **ALU decode**, active only in EXECUTER/EXECUTEI:
  - cmd 0100 → ADD.
  - cmd 0010 → SUB.
  - cmd 0000 → AND.
  - cmd 1100 → ORR.
  - cmd 1010 (CMP) → SUB with `no_write`=1.
  - Any other cmd → ADD, with `illegal` pulsed in that state. The FSM still proceeds to ALUWB; `reg_w` is not suppressed.
  - `flag_w[1]` = S.
  - `flag_w[0]` = S & (cmd is ADD, SUB or CMP).
  - Outside EXECUTER/EXECUTEI: `alu_control`=00, `flag_w`=00, `no_write`=0.

## Timing
- **During reset:** state = FETCH, so every output has its FETCH value.
  - Fixed: `alu_src_a`=1, `alu_src_b`=2, `result_src`=2, `adr_src`=0, `alu_control`=00.
  - Zero: all write requests, `flag_w`, `no_write`, `illegal`.
  - `ir_write` and `next_pc` follow `mem_ready` combinationally.
- **Instruction latency with `mem_ready` held at 1:**
  - Data-processing: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Undefined `op`: 2 cycles.
- **Memory wait states** add one cycle each, in FETCH, MEMREAD or MEMWRITE only.
- **Decoded fields** (`op`, `funct`, `rd`) must be stable from DECODE until the return to FETCH. They come from the instruction register, which is written only in FETCH.
- **`reset` asserted mid-instruction** returns to FETCH asynchronously. No write request survives: all requests are combinational from the state.
- **Output paths:** no combinational path from `mem_ready` except to `ir_write`/`next_pc` in FETCH.

## Structure
- **Package `cpu_ctrl_pkg`** holds:
  - State encoding, 4-bit localparams.
  - `op` class codes.
  - cmd codes ADD/SUB/AND/ORR/CMP.
  - `alu_src_b`/`result_src` select constants.
- **Sub-module `alu_dec`:** combinational decode of cmd + S + enable into `alu_control`, `flag_w`, `no_write`, `illegal_cmd`.
- **FSM:** one sequential block for the state register plus one combinational block for next-state and outputs.

## Test plan
- **Reset:** `reset`=0 during DECODE → state FETCH immediately; `reg_w`=`mem_w`=`pcs`=0.
- **ADD, register form:** `op`=00, `funct`=001001 (ADD, S=1), `rd`=3, `mem_ready`=1.
  - States FETCH, DECODE, EXECUTER, ALUWB.
  - In EXECUTER: `alu_control`=00, `flag_w`=11.
  - In ALUWB: `reg_w`=1, `pcs`=0.
- **LDR:** `op`=01, L=1, `mem_ready` low for 2 cycles in MEMREAD.
  - MEMREAD lasts 3 cycles with `adr_src`=1.
  - MEMWB has `result_src`=1, `reg_w`=1.
  - Total 7 cycles.
- **STR:** `op`=01, L=0, `mem_ready` low for 1 cycle.
  - `mem_w`=1 for 2 consecutive cycles, then FETCH.
- **CMP:** `funct`=110101 → `alu_control`=01, `no_write`=1, `flag_w`=11.
- **Branch and PC writeback:**
  - `op`=10 → 3-cycle sequence with `pcs`=1 in BRANCH.
  - ORR, imm, `rd`=15 → `pcs`=1 in ALUWB.
- **Undefined:** `op`=11 → `illegal` for 1 cycle in DECODE, back to FETCH.
